// File: rtl/formula_loader.sv
// Streams {var, polarity} literals into a fixed-size CNF formula image for the solver kernel.
// Malformed formulas are drained to their formula_last marker and dropped without starting the kernel.
module formula_loader #(
  parameter int MAX_CLAUSES = 10,
  parameter int MAX_LITS    = 5,
  parameter int VAR_W       = 3,
  localparam int LIT_W      = VAR_W + 1,
  localparam int LEN_W      = 3,
  localparam int CNT_W      = 4,
  localparam int CLAUSE_W   = LEN_W + MAX_LITS * LIT_W,
  localparam int FORMULA_W  = CNT_W + MAX_CLAUSES * CLAUSE_W
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 lit_valid,
  output logic                 lit_ready,
  input  logic [LIT_W-1:0]     lit_in,
  input  logic                 lit_last,
  input  logic                 formula_last,
  output logic [FORMULA_W-1:0] out_formula,
  output logic                 find,
  input  logic                 ended,
  output logic                 error
);

  localparam int CIDX_W = $clog2(MAX_CLAUSES + 1);
  localparam int LIDX_W = $clog2(MAX_LITS + 1);

  localparam logic [1:0] S_COLLECT = 2'd0;
  localparam logic [1:0] S_RUN     = 2'd1;
  localparam logic [1:0] S_DRAIN   = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [CIDX_W-1:0] clause_idx_q, clause_idx_d;
  logic [LIDX_W-1:0] lit_idx_q, lit_idx_d;
  logic              lit_ready_q, lit_ready_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [LEN_W-1:0]  lens_q [MAX_CLAUSES];
  logic [LEN_W-1:0]  lens_d [MAX_CLAUSES];
  logic [LIT_W-1:0]  lits_q [MAX_CLAUSES][MAX_LITS];
  logic [LIT_W-1:0]  lits_d [MAX_CLAUSES][MAX_LITS];

  logic handshake;
  logic bad_lit;
  logic clear_all;

  assign handshake = lit_valid & lit_ready_q;
  // Any of the three faults collapses into the same single DRAIN entry.
  assign bad_lit   = (lit_in[VAR_W:1] == '0)
                   | (lit_idx_q == LIDX_W'(MAX_LITS))
                   | (clause_idx_q == CIDX_W'(MAX_CLAUSES));

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d      = state_q;
    clause_idx_d = clause_idx_q;
    lit_idx_d    = lit_idx_q;
    count_d      = count_q;
    lens_d       = lens_q;
    lits_d       = lits_q;
    clear_all    = 1'b0;

    case (state_q)
      S_COLLECT: begin
        if (handshake) begin
          if (bad_lit) begin
            state_d = S_DRAIN;
          end else begin
            lits_d[clause_idx_q][lit_idx_q] = lit_in;
            if (lit_last) begin
              lens_d[clause_idx_q] = LEN_W'(lit_idx_q + LIDX_W'(1));
              clause_idx_d         = clause_idx_q + CIDX_W'(1);
              lit_idx_d            = '0;
              if (formula_last) begin
                count_d = CNT_W'(clause_idx_q + CIDX_W'(1));
                state_d = S_RUN;
              end
            end else begin
              lit_idx_d = lit_idx_q + LIDX_W'(1);
            end
          end
        end
      end
      S_RUN:   clear_all = ended;
      S_DRAIN: clear_all = handshake & lit_last & formula_last;
      default: clear_all = 1'b1;
    endcase

    if (clear_all) begin
      state_d      = S_COLLECT;
      clause_idx_d = '0;
      lit_idx_d    = '0;
      count_d      = '0;
      lens_d       = '{default: '0};
      lits_d       = '{default: '0};
    end

    lit_ready_d = (state_d != S_RUN);
  end

  // NOTE: the formula storage is reset explicitly because its reset image (all zero_lit) is visible at out_formula.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_COLLECT;
      clause_idx_q <= '0;
      lit_idx_q    <= '0;
      lit_ready_q  <= 1'b0;
      count_q      <= '0;
      lens_q       <= '{default: '0};
      lits_q       <= '{default: '0};
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      state_q      <= state_d;
      clause_idx_q <= clause_idx_d;
      lit_idx_q    <= lit_idx_d;
      lit_ready_q  <= lit_ready_d;
      count_q      <= count_d;
      lens_q       <= lens_d;
      lits_q       <= lits_d;
    end
  end

  // Packed image: {count, clause[MAX_CLAUSES-1..0]}, clause = {len, lit[MAX_LITS-1..0]}.
  for (genvar c = 0; c < MAX_CLAUSES; c++) begin : g_clause
    for (genvar l = 0; l < MAX_LITS; l++) begin : g_lit
      assign out_formula[c*CLAUSE_W + l*LIT_W +: LIT_W] = lits_q[c][l];
    end
    assign out_formula[c*CLAUSE_W + MAX_LITS*LIT_W +: LEN_W] = lens_q[c];
  end
  assign out_formula[MAX_CLAUSES*CLAUSE_W +: CNT_W] = count_q;

  assign lit_ready = lit_ready_q;
  assign find      = (state_q == S_RUN);
  assign error     = (state_q == S_DRAIN);

endmodule

// File: tb/tb_formula_loader.sv
// Bench for formula_loader: vector table plus hand-written sequences, with a scoreboard
// of completed formulas checked when find is raised.
module tb_formula_loader;

  localparam int MC = 10;
  localparam int ML = 5;
  localparam int VW = 3;
  localparam int LW = VW + 1;
  localparam int CW = 3 + ML * LW;
  localparam int FW = 4 + MC * CW;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          lit_valid = 1'b0;
  logic          lit_last = 1'b0;
  logic          formula_last = 1'b0;
  logic          ended = 1'b0;
  logic [VW:0]   lit_in = '0;
  logic          lit_ready;
  logic          find;
  logic          error;
  logic [FW-1:0] out_formula;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: packed formula image built by position counters.
  logic [FW-1:0] m_form;
  int            m_c;
  int            m_l;
  bit            m_drain;
  bit            m_run;
  logic [FW-1:0] sb_q [$];

  typedef struct {
    logic [VW-1:0] v;
    logic          p;
    logic          last;
    logic          fl;
    logic          do_end;
    logic          exp_find;
    logic          exp_err;
  } vec_t;

  vec_t vecs [9];

  formula_loader #(.MAX_CLAUSES(MC), .MAX_LITS(ML), .VAR_W(VW)) dut (
    .clock        (clock),
    .reset        (reset),
    .lit_valid    (lit_valid),
    .lit_ready    (lit_ready),
    .lit_in       (lit_in),
    .lit_last     (lit_last),
    .formula_last (formula_last),
    .out_formula  (out_formula),
    .find         (find),
    .ended        (ended),
    .error        (error)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    m_form  = '0;
    m_c     = 0;
    m_l     = 0;
    m_drain = 1'b0;
    m_run   = 1'b0;
  endtask

  task automatic model_accept(input logic [VW-1:0] v, input logic p, input logic last, input logic fl);
    if (m_drain) begin
      if (last && fl) model_clear();
    end else if (v == '0 || m_l == ML || m_c == MC) begin
      m_drain = 1'b1;
    end else begin
      m_form[m_c*CW + m_l*LW +: LW] = {v, p};
      if (last) begin
        m_form[m_c*CW + ML*LW +: 3] = 3'(m_l + 1);
        m_c++;
        m_l = 0;
        if (fl) begin
          m_form[MC*CW +: 4] = 4'(m_c);
          m_run = 1'b1;
          sb_q.push_back(m_form);
        end
      end else begin
        m_l++;
      end
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the handshake.
  task automatic send_lit(input logic [VW-1:0] v, input logic p, input logic last, input logic fl);
    int waited;
    lit_in       = {v, p};
    lit_last     = last;
    formula_last = fl;
    lit_valid    = 1'b1;
    waited       = 0;
    while (!lit_ready && waited < 20) begin
      @(negedge clock);
      waited++;
    end
    if (!lit_ready) begin
      n_checks++;
      n_errors++;
      $display("FAIL lit_ready_timeout: got 0 expected 1 within 20 cycles");
      lit_valid = 1'b0;
    end else begin
      @(negedge clock);
      lit_valid = 1'b0;
      model_accept(v, p, last, fl);
    end
  endtask

  task automatic sb_pop_check(input string name);
    logic [FW-1:0] exp;
    n_checks++;
    if (sb_q.size() == 0) begin
      n_errors++;
      $display("FAIL %s: got find with empty scoreboard expected a pending formula", name);
    end else begin
      n_checks--;
      exp = sb_q.pop_front();
      check(name, out_formula, exp);
    end
  endtask

  task automatic pulse_ended();
    ended = 1'b1;
    @(negedge clock);
    ended = 1'b0;
    if (m_run) model_clear();
  endtask

  initial begin
    logic [FW-1:0] exp38;
    logic [FW-1:0] held;

    vecs[0] = '{3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{3'd3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{3'd7, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{3'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{3'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{3'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{3'd6, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    exp38 = '0;
    exp38[0 +: 4]          = 4'b0011;
    exp38[LW +: 4]         = 4'b0101;
    exp38[ML*LW +: 3]      = 3'b010;
    exp38[CW +: 4]         = 4'b0110;
    exp38[CW + ML*LW +: 3] = 3'b001;
    exp38[MC*CW +: 4]      = 4'b0010;

    model_clear();

    // Reset state.
    #3;
    check("rst_lit_ready", lit_ready, 0);
    check("rst_find", find, 0);
    check("rst_error", error, 0);
    check("rst_formula", out_formula, '0);
    @(negedge clock);
    reset = 1'b0;
    check("rst_release_ready_low", lit_ready, 0);
    @(negedge clock);
    check("ready_after_first_edge", lit_ready, 1);

    // Vector table.
    for (int i = 0; i < 9; i++) begin
      send_lit(vecs[i].v, vecs[i].p, vecs[i].last, vecs[i].fl);
      check($sformatf("v%0d_find", i), find, vecs[i].exp_find);
      check($sformatf("v%0d_error", i), error, vecs[i].exp_err);
      check($sformatf("v%0d_ready", i), lit_ready, !vecs[i].exp_find);
      if (vecs[i].exp_find) sb_pop_check($sformatf("v%0d_sb_formula", i));
      else check($sformatf("v%0d_formula", i), out_formula, m_form);
      if (i == 2) check("req038_formula", out_formula, exp38);
      if (vecs[i].do_end) begin
        pulse_ended();
        check($sformatf("v%0d_end_find", i), find, 0);
        check($sformatf("v%0d_end_ready", i), lit_ready, 1);
        check($sformatf("v%0d_end_formula", i), out_formula, '0);
      end
    end

    // Full 5x5 formula, then held lit_valid during RUN.
    for (int c = 0; c < 5; c++)
      for (int l = 0; l < 5; l++)
        send_lit(3'(((c + l) % 7) + 1), 1'(l % 2), l == 4, (c == 4) && (l == 4));
    check("max_find", find, 1);
    sb_pop_check("max_sb_formula");
    check("max_count", out_formula[MC*CW +: 4], 4'b0101);
    for (int c = 0; c < 5; c++)
      check($sformatf("max_len%0d", c), out_formula[c*CW + ML*LW +: 3], 3'b101);
    held      = out_formula;
    lit_in    = 4'b1011;
    lit_last  = 1'b1;
    formula_last = 1'b1;
    lit_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      check($sformatf("run_hold_ready%0d", k), lit_ready, 0);
      check($sformatf("run_hold_formula%0d", k), out_formula, held);
    end
    ended = 1'b1;
    @(negedge clock);
    ended     = 1'b0;
    lit_valid = 1'b0;
    model_clear();
    check("run_end_find", find, 0);
    check("run_end_ready", lit_ready, 1);
    check("run_end_count", out_formula[MC*CW +: 4], 4'b0000);

    // Overflow: 6th literal carries lit_last and formula_last, error wins.
    for (int l = 0; l < 5; l++) begin
      send_lit(3'(l + 1), 1'b1, 1'b0, 1'b0);
      check($sformatf("ovf_err_lit%0d", l), error, 0);
    end
    send_lit(3'd6, 1'b0, 1'b1, 1'b1);
    check("ovf_error", error, 1);
    check("ovf_find", find, 0);
    pulse_ended();
    check("drain_ignores_ended", error, 1);
    send_lit(3'd1, 1'b1, 1'b1, 1'b1);
    check("ovf_term_error", error, 0);
    check("ovf_term_ready", lit_ready, 1);
    check("ovf_term_formula", out_formula, '0);

    // Clause overflow and var=0 in a fresh formula.
    for (int c = 0; c < 10; c++) send_lit(3'((c % 7) + 1), 1'b0, 1'b1, 1'b0);
    check("cl10_error", error, 0);
    check("cl10_formula", out_formula, m_form);
    send_lit(3'd2, 1'b1, 1'b1, 1'b0);
    check("cl11_error", error, 1);
    send_lit(3'd2, 1'b1, 1'b1, 1'b1);
    check("cl11_term_error", error, 0);
    send_lit(3'd0, 1'b0, 1'b0, 1'b0);
    check("var0_error", error, 1);
    send_lit(3'd3, 1'b0, 1'b1, 1'b1);
    check("var0_term_formula", out_formula, '0);

    // ended in COLLECT, then asynchronous reset mid-collection.
    send_lit(3'd5, 1'b1, 1'b0, 1'b0);
    pulse_ended();
    check("collect_ignores_ended", out_formula, m_form);
    send_lit(3'd6, 1'b0, 1'b0, 1'b0);
    send_lit(3'd7, 1'b1, 1'b0, 1'b0);
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    model_clear();
    check("async_rst_formula", out_formula, '0);
    check("async_rst_ready", lit_ready, 0);
    check("async_rst_find", find, 0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    send_lit(3'd3, 1'b1, 1'b1, 1'b1);
    check("post_rst_find", find, 1);
    sb_pop_check("post_rst_sb_formula");
    check("post_rst_slot0", out_formula[0 +: 4], 4'b0111);
    pulse_ended();
    check("sb_empty", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/formula_loader.md
FORMULA_LOADER -- requirements
Module: formula_loader

Interface
REQ-001 The module SHALL use the parameter MAX_CLAUSES, default 10, as the number of clause slots in the formula type.
REQ-002 The module SHALL use the parameter MAX_LITS, default 5, as the number of literal slots per clause.
REQ-003 The module SHALL use the parameter VAR_W, default 3, as the variable index width, where index 0 is reserved for zero_lit.
REQ-004 The module SHALL have port clock, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The module SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The module SHALL have port lit_valid, input, 1 bit: the producer offers a literal.
REQ-007 The module SHALL have port lit_ready, output, 1 bit: the loader accepts a literal this cycle.
REQ-008 The module SHALL have port lit_in, input, VAR_W+1 bits: {var, polarity}, in the same layout as the common lit type.
REQ-009 The module SHALL have port lit_last, input, 1 bit: the literal is the last of its clause.
REQ-010 The module SHALL have port formula_last, input, 1 bit: qualified by lit_last, the clause is the last of the formula.
REQ-011 The module SHALL have port out_formula, output, common formula type: the assembled formula, wired to the DB_kernel in_formula input.
REQ-012 The module SHALL have port find, output, 1 bit: the formula is complete and stable; this is the kernel start request.
REQ-013 The module SHALL have port ended, input, 1 bit: the kernel has finished solving.
REQ-014 The module SHALL have port error, output, 1 bit: the current formula is malformed and is being discarded.

Function
REQ-015 The module SHALL define a handshake as lit_valid & lit_ready at a rising clock edge; with no handshake, no storage or state changes.
REQ-016 The module SHALL implement the states COLLECT, RUN and DRAIN, with COLLECT entered from reset.
REQ-017 In COLLECT, lit_ready SHALL be 1, find SHALL be 0 and error SHALL be 0.
REQ-018 On a COLLECT handshake, the module SHALL store lit_in in clause slot clause_idx, literal slot lit_idx, and increment lit_idx; the first received clause and literal go to index 0.
REQ-019 On a COLLECT handshake with lit_last=1, the module SHALL write the clause length as lit_idx+1 (3-bit), increment clause_idx and clear lit_idx.
REQ-020 On a COLLECT handshake with lit_last=1 and formula_last=1, the module SHALL write the clause count as clause_idx+1 (4-bit) and enter RUN.
REQ-021 The module SHALL ignore formula_last when lit_last=0.
REQ-022 Unfilled literal slots SHALL hold zero_lit, and unfilled clauses SHALL hold all zero_lit with length 0.
REQ-023 In RUN, find SHALL be 1, lit_ready SHALL be 0, and out_formula SHALL be held constant.
REQ-024 find SHALL rise on the edge that accepts the final literal, giving 1-cycle latency from that handshake.
REQ-025 In RUN with ended=1, the module SHALL drop find on the next edge, clear all storage, clause_idx and lit_idx to zero/zero_lit, and enter COLLECT.
REQ-026 The module SHALL ignore ended in COLLECT and DRAIN.
REQ-027 A COLLECT handshake with a var field of 0 SHALL cause error.
REQ-028 A COLLECT handshake with lit_idx==MAX_LITS SHALL cause error.
REQ-029 A COLLECT handshake with clause_idx==MAX_CLAUSES SHALL cause error.
REQ-030 On error, the module SHALL enter DRAIN on that edge, store nothing, and never assert find for that formula.
REQ-031 In DRAIN, error SHALL be 1 and lit_ready SHALL be 1, and all accepted literals SHALL be discarded.
REQ-032 A DRAIN handshake with lit_last=1 and formula_last=1 SHALL clear storage, drop error on the next edge and enter COLLECT.
REQ-033 When a single literal triggers more than one error condition, the module SHALL produce the same single DRAIN entry.
REQ-034 When the literal that completes a clause also overflows (a 6th literal with lit_last), the error SHALL take priority over completion.

Reset
REQ-035 While reset=1, asynchronously: state=COLLECT, clause_idx=0, lit_idx=0, out_formula all zero_lit with all lengths 0 and count 0, find=0, error=0, lit_ready=0.
REQ-036 lit_ready SHALL become 1 on the first edge after reset deasserts.
REQ-037 Reset asserted mid-collection or during RUN SHALL discard the partial or active formula with no pending find.

Verification
REQ-038 Send (x1,+)(x2,+ last), then (x3,- last, formula_last) -> the next cycle shows find=1, count=4'b0010, clause0 length 3'b010 lits {001,1},{010,1}, clause1 length 3'b001 lit {011,0}, and the rest zero_lit.
REQ-039 Send 5 clauses of 5 literals each (max width), with formula_last on the 5th -> find=1, all lengths 3'b101, count 4'b0101.
REQ-040 Send 6 literals without lit_last -> error=1 after the 6th handshake, find stays 0; then send a terminating literal -> error=0 and lit_ready=1, with storage all zero_lit.
REQ-041 Send 11 single-literal clauses -> error on the 11th handshake; send var=0 in a fresh formula -> error on the 1st handshake.
REQ-042 In RUN, hold lit_valid=1 for 5 cycles, then pulse ended -> no literal is accepted while find=1; find=0 and lit_ready=1 one cycle after ended, with count 0.
REQ-043 Assert reset asynchronously between clock edges after 3 accepted literals -> all outputs are zero immediately; a subsequent 1-clause formula loads into slot 0.
